// File: rtl/mtsp_alu_simd_ba_if.sv
// Operand/result handshake bundle for the packed-SIMD byte-arithmetic unit.
// master drives operands and out_ready; slave is the ALU.
interface mtsp_alu_simd_ba_if #(
  parameter int LW    = 8,
  parameter int LANES = 4
);
  localparam int DW = LW * LANES;

  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_mode;
  logic [DW-1:0] src0a;
  logic [DW-1:0] src0b;
  logic [DW-1:0] src1a;
  logic [DW-1:0] src1b;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_mode;
  logic [DW-1:0] dout0;
  logic [DW-1:0] dout1;

  modport master (
    output in_valid, in_mode, src0a, src0b,
    output src1a, src1b, out_ready,
    input  in_ready, out_valid, out_mode,
    input  dout0, dout1
  );

  modport slave (
    input  in_valid, in_mode, src0a, src0b,
    input  src1a, src1b, out_ready,
    output in_ready, out_valid, out_mode,
    output dout0, dout1
  );
endinterface

// File: rtl/mtsp_alu_simd_ba.sv
// Packed-SIMD saturating add/sub and 2-/4-way average, 2-stage valid/ready pipe.
// Define MTSP_ALU_BA_ROUND_EN for round-half-up averages (default truncates).
module mtsp_alu_simd_ba #(
  parameter int LW    = 8,
  parameter int LANES = 4
) (
  input logic               clk,
  input logic               rst,
  mtsp_alu_simd_ba_if.slave bus
);
  localparam int DW = LW * LANES;
  localparam int SW = LW + 1;
  localparam int AW = LW + 2;
  localparam int PW = SW * LANES;

  localparam logic [1:0] ADDS = 2'd0;
  localparam logic [1:0] SUBS = 2'd1;
  localparam logic [1:0] AVG2 = 2'd2;

`ifdef MTSP_ALU_BA_ROUND_EN
  localparam logic [AW-1:0] R1 = AW'(1);
  localparam logic [AW-1:0] R2 = AW'(2);
`else
  localparam logic [AW-1:0] R1 = '0;
  localparam logic [AW-1:0] R2 = '0;
`endif

  logic          s1_valid;
  logic [1:0]    s1_mode;
  logic [PW-1:0] s1_p0;
  logic [PW-1:0] s1_p1;

  logic          out_valid;
  logic [1:0]    out_mode;
  logic [DW-1:0] dout0;
  logic [DW-1:0] dout1;

  logic          adv1;
  logic          adv2;
  logic [PW-1:0] p0_d;
  logic [PW-1:0] p1_d;
  logic [DW-1:0] r0_d;
  logic [DW-1:0] r1_d;
  logic [SW-1:0] a0, b0, a1, b1;
  logic [SW-1:0] x0, x1;

  assign adv2 = ~out_valid | bus.out_ready;
  assign adv1 = ~s1_valid | adv2;

  assign bus.in_ready  = adv1;
  assign bus.out_valid = out_valid;
  assign bus.out_mode  = out_mode;
  assign bus.dout0     = dout0;
  assign bus.dout1     = dout1;

  // EX0: one LW+1 bit sum (or diff, MSB = borrow) per lane and phase
  always_comb begin
    p0_d = '0;
    p1_d = '0;
    a0   = '0;
    b0   = '0;
    a1   = '0;
    b1   = '0;
    for (int l = 0; l < LANES; l++) begin
      a0 = {1'b0, bus.src0a[l*LW +: LW]};
      b0 = {1'b0, bus.src0b[l*LW +: LW]};
      a1 = {1'b0, bus.src1a[l*LW +: LW]};
      b1 = {1'b0, bus.src1b[l*LW +: LW]};
      if (bus.in_mode == SUBS) begin
        p0_d[l*SW +: SW] = a0 - b0;
        p1_d[l*SW +: SW] = a1 - b1;
      end else begin
        p0_d[l*SW +: SW] = a0 + b0;
        p1_d[l*SW +: SW] = a1 + b1;
      end
    end
  end

  // EX1: saturate or average; AVG4 widens to LW+2 so nothing wraps
  always_comb begin
    r0_d = '0;
    r1_d = '0;
    x0   = '0;
    x1   = '0;
    for (int l = 0; l < LANES; l++) begin
      x0 = s1_p0[l*SW +: SW];
      x1 = s1_p1[l*SW +: SW];
      unique case (s1_mode)
        ADDS: begin
          r0_d[l*LW +: LW] = x0[LW] ? '1 : x0[LW-1:0];
          r1_d[l*LW +: LW] = x1[LW] ? '1 : x1[LW-1:0];
        end
        SUBS: begin
          r0_d[l*LW +: LW] = x0[LW] ? '0 : x0[LW-1:0];
          r1_d[l*LW +: LW] = x1[LW] ? '0 : x1[LW-1:0];
        end
        AVG2: begin
          r0_d[l*LW +: LW] = LW'((AW'(x0) + R1) >> 1);
          r1_d[l*LW +: LW] = LW'((AW'(x1) + R1) >> 1);
        end
        default: begin
          r0_d[l*LW +: LW] = LW'((AW'(x0) + AW'(x1) + R2) >> 2);
          r1_d[l*LW +: LW] = LW'((AW'(x0) + AW'(x1) + R2) >> 2);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_mode   <= '0;
      s1_p0     <= '0;
      s1_p1     <= '0;
      out_valid <= 1'b0;
      out_mode  <= '0;
      dout0     <= '0;
      dout1     <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_mode <= bus.in_mode;
          s1_p0   <= p0_d;
          s1_p1   <= p1_d;
        end
      end
      if (adv2) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_mode <= s1_mode;
          dout0    <= r0_d;
          dout1    <= r1_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_mtsp_alu_simd_ba.sv
// Directed bench for mtsp_alu_simd_ba (LW=8, LANES=4).
// Expected values are hand-computed; rounding build selected by MTSP_ALU_BA_ROUND_EN.
module tb_mtsp_alu_simd_ba;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

`ifdef MTSP_ALU_BA_ROUND_EN
  localparam logic [31:0] AVG4_EXP = 32'h01010100;
  localparam logic [31:0] AVG2_EXP = 32'h18182841;
`else
  localparam logic [31:0] AVG4_EXP = 32'h01000000;
  localparam logic [31:0] AVG2_EXP = 32'h18182840;
`endif

  mtsp_alu_simd_ba_if #(.LW(8), .LANES(4)) bus ();

  mtsp_alu_simd_ba #(.LW(8), .LANES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic [31:0] a0,
                       input logic [31:0] b0, input logic [31:0] a1,
                       input logic [31:0] b1);
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.src0a    = a0;
    bus.src0b    = b0;
    bus.src1a    = a1;
    bus.src1b    = b1;
  endtask

  // present one set for one cycle, then wait for its result (2 edges)
  task automatic run(input logic [1:0] m, input logic [31:0] a0,
                     input logic [31:0] b0, input logic [31:0] a1,
                     input logic [31:0] b1);
    drive(m, a0, b0, a1, b1);
    step();
    bus.in_valid = 1'b0;
    step();
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 2'd0;
    bus.src0a     = '0;
    bus.src0b     = '0;
    bus.src1a     = '0;
    bus.src1b     = '0;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_dout0", bus.dout0, 32'h0);
    chk("rst_dout1", bus.dout1, 32'h0);
    chk("rst_out_mode", 32'(bus.out_mode), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    step();

    drive(2'd0, 32'h80FF1020, 32'h80010F10, 32'h7F7F7F7F, 32'h01010101);
    step();
    bus.in_valid = 1'b0;
    chk("adds_lat1_valid", 32'(bus.out_valid), 32'd0);
    step();
    chk("adds_valid", 32'(bus.out_valid), 32'd1);
    chk("adds_dout0", bus.dout0, 32'hFFFF1F30);
    chk("adds_nocarry", bus.dout1, 32'h80808080);
    chk("adds_mode", 32'(bus.out_mode), 32'd0);
    step();
    chk("adds_drain", 32'(bus.out_valid), 32'd0);

    run(2'd1, 32'h10203040, 32'h20102040, 32'hFFFFFFFF, 32'h00000001);
    chk("subs_dout0", bus.dout0, 32'h00101000);
    chk("subs_dout1", bus.dout1, 32'hFFFFFFFE);
    chk("subs_mode", 32'(bus.out_mode), 32'd1);

    run(2'd2, 32'h10203040, 32'h20102041, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("avg2_dout0", bus.dout0, AVG2_EXP);
    chk("avg2_dout1", bus.dout1, 32'hFFFFFFFF);
    chk("avg2_mode", 32'(bus.out_mode), 32'd2);

    run(2'd3, 32'h04030201, 32'h0, 32'h0, 32'h0);
    chk("avg4_dout0", bus.dout0, AVG4_EXP);
    chk("avg4_dout1", bus.dout1, AVG4_EXP);
    chk("avg4_mode", 32'(bus.out_mode), 32'd3);

    run(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("avg4_max0", bus.dout0, 32'hFFFFFFFF);
    chk("avg4_max1", bus.dout1, 32'hFFFFFFFF);
    step();

    // backpressure: three back-to-back sets with the sink stalled
    bus.out_ready = 1'b0;
    drive(2'd0, 32'h01010101, 32'h01010101, 32'h0, 32'h0);
    step();
    chk("bp_ready_a", 32'(bus.in_ready), 32'd1);
    drive(2'd0, 32'h03030303, 32'h03030303, 32'h0, 32'h0);
    step();
    drive(2'd1, 32'h10101010, 32'h0, 32'h0, 32'h0);
    chk("bp_ready_c", 32'(bus.in_ready), 32'd0);
    chk("bp_valid_a", 32'(bus.out_valid), 32'd1);
    chk("bp_dout_a", bus.dout0, 32'h02020202);
    step();
    step();
    chk("bp_hold_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_hold_dout", bus.dout0, 32'h02020202);
    chk("bp_hold_mode", 32'(bus.out_mode), 32'd0);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_dout_b", bus.dout0, 32'h06060606);
    chk("bp_valid_b", 32'(bus.out_valid), 32'd1);
    step();
    chk("bp_dout_c", bus.dout0, 32'h10101010);
    chk("bp_mode_c", 32'(bus.out_mode), 32'd1);
    step();
    chk("bp_drain", 32'(bus.out_valid), 32'd0);

    // reset with both stages holding data
    bus.out_ready = 1'b0;
    drive(2'd0, 32'h11111111, 32'h11111111, 32'h22222222, 32'h0);
    step();
    step();
    bus.in_valid = 1'b0;
    chk("flush_pre_full", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_dout0", bus.dout0, 32'h0);
    chk("flush_dout1", bus.dout1, 32'h0);
    chk("flush_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    step();
    chk("flush_stale1", 32'(bus.out_valid), 32'd0);
    step();
    chk("flush_stale2", 32'(bus.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
